// File: rtl/bus_pkg.sv
// Shared definitions for the strobe/ack CPU memory bus: FSM state encoding,
// byte-lane select constants and the address window decode helper.
package bus_pkg;

    // Bus data width and the matching number of byte lanes.
    localparam int BUS_DW   = 32;
    localparam int BUS_SELW = BUS_DW / 8;

    // Responder handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Byte-lane select patterns; bit n enables dat[8n+7:8n].
    localparam logic [BUS_SELW-1:0] SEL_BYTE0   = 4'b0001;
    localparam logic [BUS_SELW-1:0] SEL_BYTE1   = 4'b0010;
    localparam logic [BUS_SELW-1:0] SEL_BYTE2   = 4'b0100;
    localparam logic [BUS_SELW-1:0] SEL_BYTE3   = 4'b1000;
    localparam logic [BUS_SELW-1:0] SEL_HALF_LO = 4'b0011;
    localparam logic [BUS_SELW-1:0] SEL_HALF_HI = 4'b1100;
    localparam logic [BUS_SELW-1:0] SEL_WORD    = 4'b1111;

    // True when a byte address falls inside the window of 2**(aw+2) bytes
    // that starts at base (base is expected to be aligned to that size).
    function automatic logic window_hit(input logic [31:0] adr,
                                        input logic [31:0] base,
                                        input int          aw);
        return (adr >> (aw + 2)) == (base >> (aw + 2));
    endfunction

endpackage

// File: rtl/bus_ram_slave_if.sv
// Strobe/ack memory bus bundle. The master drives the request side, the
// responder drives ack and read data.
interface bus_ram_slave_if;
    import bus_pkg::*;

    logic                stb_i;
    logic                we_i;
    logic [31:0]         adr_i;
    logic [BUS_DW-1:0]   dat_i;
    logic [BUS_SELW-1:0] sel_i;
    logic                ack_o;
    logic [BUS_DW-1:0]   dat_o;

    modport master (
        output stb_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  stb_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, dat_o
    );

endinterface

// File: rtl/bus_ram_array.sv
// Single-port word RAM built from one byte-wide array per lane, with a
// per-lane write enable and a registered read port. The read register is
// the bus read-data output, so it is cleared by reset and only changes on
// a read access; writes leave it untouched.
module bus_ram_array
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  en,
    input  logic                  we,
    input  logic [BUS_SELW-1:0]   be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BUS_DW-1:0]     wdata,
    output logic [BUS_DW-1:0]     rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    for (genvar gi = 0; gi < BUS_SELW; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];
        logic [7:0] rd_lane_reg;

        // Lane write: only this byte changes when its enable is set.
        always_ff @(posedge clk) begin
            if (en && we && be[gi]) begin
                mem_lane[addr] <= wdata[gi*8 +: 8];
            end
        end

        // Registered read; holds its value across writes and idle cycles.
        always_ff @(posedge clk or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_lane_reg <= 8'h00;
            end else if (en && !we) begin
                rd_lane_reg <= mem_lane[addr];
            end
        end

        assign rdata[gi*8 +: 8] = rd_lane_reg;
    end

endmodule

// File: rtl/bus_ram_slave.sv
// RAM responder for the CPU strobe/ack bus. Decodes its address window,
// latches the request, waits WAIT_STATES extra cycles and then performs the
// RAM access on the same edge that raises ack. Ack is held until the master
// drops strobe (four-phase handshake). Dropping strobe before ack aborts the
// request without touching the RAM.
module bus_ram_slave
    import bus_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst_ni,
    bus_ram_slave_if.slave   bus
);

    // Wait-state count loaded at acceptance; it counts the cycles still to
    // spend in WAIT before the access edge, so ack rises 1 + WAIT_STATES
    // edges after the acceptance edge.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  ack_reg, ack_next;

    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] adr_reg;
    logic [BUS_DW-1:0]     dat_reg;
    logic [BUS_SELW-1:0]   sel_reg;

    logic                  hit;
    logic                  accept;
    logic                  ram_en;
    logic [BUS_DW-1:0]     ram_rdata;

    assign hit = window_hit(bus.adr_i, BASE_ADDR, ADDR_WIDTH);

    // State, wait counter and registered ack.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= ack_next;
        end
    end

    // Capture the request at acceptance; later bus changes are ignored.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            we_reg  <= 1'b0;
            adr_reg <= '0;
            dat_reg <= '0;
            sel_reg <= '0;
        end else if (accept) begin
            we_reg  <= bus.we_i;
            adr_reg <= bus.adr_i[ADDR_WIDTH+1:2];
            dat_reg <= bus.dat_i;
            sel_reg <= bus.sel_i;
        end
    end

    // Next-state logic: accept, count down wait states, abort on strobe
    // loss, hold ack until strobe drops.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.stb_i && hit && !ack_reg) begin
                    state_next = WAIT;
                    cnt_next   = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (!bus.stb_i) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == 4'd0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ACK: begin
                if (!bus.stb_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Output decode: acceptance strobe, the single RAM access pulse on ACK
    // entry, and the value ack takes at the next edge.
    always_comb begin
        accept   = (state_reg == IDLE) && bus.stb_i && hit && !ack_reg;
        ram_en   = (state_reg == WAIT) && bus.stb_i && (cnt_reg == 4'd0);
        ack_next = (state_next == ACK);
    end

    bus_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst_ni (rst_ni),
        .en     (ram_en),
        .we     (we_reg),
        .be     (sel_reg),
        .addr   (adr_reg),
        .wdata  (dat_reg),
        .rdata  (ram_rdata)
    );

    assign bus.ack_o = ack_reg;
    assign bus.dat_o = ram_rdata;

endmodule

// File: tb/tb_bus_ram_slave.sv
// Directed bench for bus_ram_slave: one instance with one wait state and one
// with three, sharing the request signals; tgt3 picks which one sees strobe.
module tb_bus_ram_slave;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic        tgt3 = 1'b0;

    int checks = 0;
    int errors = 0;

    bus_ram_slave_if bus1 ();
    bus_ram_slave_if bus3 ();

    assign bus1.stb_i = stb && !tgt3;
    assign bus1.we_i  = we;
    assign bus1.adr_i = adr;
    assign bus1.dat_i = dat;
    assign bus1.sel_i = sel;
    assign bus3.stb_i = stb && tgt3;
    assign bus3.we_i  = we;
    assign bus3.adr_i = adr;
    assign bus3.dat_i = dat;
    assign bus3.sel_i = sel;

    logic        ack_mux;
    logic [31:0] dat_mux;
    assign ack_mux = tgt3 ? bus3.ack_o : bus1.ack_o;
    assign dat_mux = tgt3 ? bus3.dat_o : bus1.dat_o;

    bus_ram_slave #(
        .ADDR_WIDTH  (10),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_STATES (1)
    ) dut1 (
        .clk    (clk),
        .rst_ni (rst_n),
        .bus    (bus1.slave)
    );

    bus_ram_slave #(
        .ADDR_WIDTH  (10),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_STATES (3)
    ) dut3 (
        .clk    (clk),
        .rst_ni (rst_n),
        .bus    (bus3.slave)
    );

    always #5 clk = ~clk;

    // Full handshake, started at a negedge. edges = number of clock edges
    // from the acceptance edge to the edge that raised ack (-1 on timeout).
    task automatic xfer(input logic t3, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int edges, output logic [31:0] rd,
                        output logic dropped);
        tgt3 = t3; we = w; adr = a; dat = d; sel = s; stb = 1'b1;
        edges = -1; rd = 32'h0; dropped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_mux) begin
                edges = i;
                break;
            end
        end
        rd = dat_mux;
        stb = 1'b0;
        @(negedge clk);
        dropped = !ack_mux;
        $display("[%0t] dut%0d %s adr=%h wdat=%h sel=%b ack_edges=%0d rdat=%h",
                 $time, t3 ? 3 : 1, w ? "WR" : "RD", a, d, s, edges, rd);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus1.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b want 0", bus1.ack_o); end
        checks++;
        if (bus1.dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat1: got %h want 00000000", bus1.dat_o); end
        checks++;
        if (bus3.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack3: got %b want 0", bus3.ack_o); end
        checks++;
        if (bus3.dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat3: got %h want 00000000", bus3.dat_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_read();
        int e; logic [31:0] r; logic dr;
        xfer(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, SEL_WORD, e, r, dr);
        checks++;
        if (e !== 2) begin errors++; $display("FAIL preload_latency: got %0d want 2", e); end
        xfer(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (e !== 2) begin errors++; $display("FAIL read_latency: got %0d want 2", e); end
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL read_init: got %h want 00000000", r); end
        checks++;
        if (dr !== 1'b1) begin errors++; $display("FAIL ack_release: ack still high after stb drop"); end
    endtask

    task automatic test_word_write();
        int e; logic [31:0] r; logic dr;
        xfer(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, SEL_WORD, e, r, dr);
        checks++;
        if (e !== 2) begin errors++; $display("FAIL write_latency: got %0d want 2", e); end
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL write_keeps_dat: got %h want 00000000", r); end
        xfer(1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_readback: got %h want deadbeef", r); end
    endtask

    task automatic test_byte_lanes();
        int e; logic [31:0] r; logic dr;
        xfer(1'b0, 1'b1, 32'h0000_0040, 32'h1122_3344, SEL_WORD, e, r, dr);
        xfer(1'b0, 1'b1, 32'h0000_0040, 32'h00AB_0000, SEL_BYTE2, e, r, dr);
        xfer(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (r !== 32'h11AB_3344) begin errors++; $display("FAIL lane_byte2: got %h want 11ab3344", r); end
        xfer(1'b0, 1'b1, 32'h0000_0040, 32'h0000_CAFE, SEL_HALF_LO, e, r, dr);
        xfer(1'b0, 1'b0, 32'h0000_0043, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (r !== 32'h11AB_CAFE) begin errors++; $display("FAIL lane_half_lo: got %h want 11abcafe", r); end
        xfer(1'b0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000, e, r, dr);
        checks++;
        if (e !== 2) begin errors++; $display("FAIL sel0_ack: got %0d want 2", e); end
        xfer(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (r !== 32'h11AB_CAFE) begin errors++; $display("FAIL sel0_unchanged: got %h want 11abcafe", r); end
    endtask

    task automatic test_window_miss();
        int e; int acks; logic [31:0] r; logic dr;
        acks = 0;
        tgt3 = 1'b0; we = 1'b1; adr = 32'h0001_0020; dat = 32'h0BAD_0BAD; sel = SEL_WORD; stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_mux) acks++;
        end
        stb = 1'b0;
        @(negedge clk);
        $display("[%0t] dut1 WR adr=00010020 (outside window) acks=%0d", $time, acks);
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL miss_ack: got %0d acks want 0", acks); end
        xfer(1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_no_write: got %h want deadbeef", r); end
    endtask

    task automatic test_abort();
        int e; int acks; logic [31:0] r; logic dr;
        xfer(1'b1, 1'b1, 32'h0000_0004, 32'hA5A5_0004, SEL_WORD, e, r, dr);
        checks++;
        if (e !== 4) begin errors++; $display("FAIL ws3_latency: got %0d want 4", e); end
        acks = 0;
        tgt3 = 1'b1; we = 1'b1; adr = 32'h0000_0004; dat = 32'h1234_5678; sel = SEL_WORD; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_mux) acks++;
        end
        $display("[%0t] dut3 WR adr=00000004 wdat=12345678 aborted acks=%0d", $time, acks);
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
        xfer(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (r !== 32'hA5A5_0004) begin errors++; $display("FAIL abort_no_write: got %h want a5a50004", r); end
        tgt3 = 1'b0;
    endtask

    task automatic test_latched_inputs();
        int e; logic [31:0] r; logic dr;
        e = -1;
        tgt3 = 1'b0; we = 1'b1; adr = 32'h0000_0024; dat = 32'h0BAD_F00D; sel = SEL_WORD; stb = 1'b1;
        @(negedge clk);
        adr = 32'h0000_0028; dat = 32'hFFFF_FFFF; sel = 4'b0000; we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ack_mux) begin e = i; break; end
            @(negedge clk);
        end
        stb = 1'b0;
        @(negedge clk);
        $display("[%0t] dut1 WR adr=00000024 wdat=0badf00d inputs changed after accept", $time);
        checks++;
        if (e < 0) begin errors++; $display("FAIL latched_ack: got timeout want ack"); end
        xfer(1'b0, 1'b0, 32'h0000_0024, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (r !== 32'h0BAD_F00D) begin errors++; $display("FAIL latched_data: got %h want 0badf00d", r); end
    endtask

    task automatic test_handshake_hold();
        int e; logic [31:0] r; logic dr; logic got;
        got = 1'b0;
        tgt3 = 1'b0; we = 1'b0; adr = 32'h0000_0020; sel = 4'h0; stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_mux) begin got = 1'b1; break; end
        end
        checks++;
        if (got !== 1'b1) begin errors++; $display("FAIL hold_ack_rise: got timeout want ack"); end
        for (int i = 0; i < 6; i++) begin
            adr = 32'h0000_0040 + 32'(i * 4);
            @(negedge clk);
            checks++;
            if (ack_mux !== 1'b1) begin errors++; $display("FAIL hold_ack[%0d]: got %b want 1", i, ack_mux); end
            checks++;
            if (dat_mux !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_dat[%0d]: got %h want deadbeef", i, dat_mux); end
        end
        stb = 1'b0;
        @(negedge clk);
        $display("[%0t] dut1 RD adr=00000020 held 6 cycles rdat=%h", $time, dat_mux);
        checks++;
        if (ack_mux !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", ack_mux); end
        xfer(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (e !== 2) begin errors++; $display("FAIL reaccept_latency: got %0d want 2", e); end
        checks++;
        if (r !== 32'h11AB_CAFE) begin errors++; $display("FAIL reaccept_data: got %h want 11abcafe", r); end
    endtask

    task automatic test_async_reset();
        int e; logic [31:0] r; logic dr; logic got;
        got = 1'b0;
        tgt3 = 1'b0; we = 1'b0; adr = 32'h0000_0040; sel = 4'h0; stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_mux) begin got = 1'b1; break; end
        end
        checks++;
        if (got !== 1'b1 || dat_mux !== 32'h11AB_CAFE) begin
            errors++; $display("FAIL pre_reset_ack: got ack=%b dat=%h want ack=1 dat=11abcafe", ack_mux, dat_mux);
        end
        #2 rst_n = 1'b0;
        #1;
        $display("[%0t] dut1 RD adr=00000040 reset asserted mid-ack", $time);
        checks++;
        if (bus1.ack_o !== 1'b0) begin errors++; $display("FAIL async_ack: got %b want 0", bus1.ack_o); end
        checks++;
        if (bus1.dat_o !== 32'h0) begin errors++; $display("FAIL async_dat: got %h want 00000000", bus1.dat_o); end
        stb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (r !== 32'h11AB_CAFE) begin errors++; $display("FAIL post_reset_40: got %h want 11abcafe", r); end
        xfer(1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, e, r, dr);
        checks++;
        if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL post_reset_20: got %h want deadbeef", r); end
    endtask

    initial begin
        test_reset();
        test_reset_read();
        test_word_write();
        test_byte_lanes();
        test_window_miss();
        test_abort();
        test_latched_inputs();
        test_handshake_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
